// File: rtl/int_reg_file.sv
// Integer physical register file with 1-cycle registered read ports, write-through
// bypass, and a post-reset sweep that zeroes every entry before reporting ready.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | clearing entry[cnt] each cycle; writes ignored, reads give 0
//   ST_RUN  | normal operation, OUT_ready high until the next reset
module int_reg_file #(
    parameter int NUM_READ  = 6,
    parameter int NUM_WRITE = 4,
    parameter int NUM_REGS  = 64,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_READ-1:0]           IN_rdValid,
    input  logic [NUM_READ*TAG_W-1:0]     IN_rdTag,
    output logic [NUM_READ*DATA_W-1:0]    OUT_rdData,
    input  logic [NUM_WRITE-1:0]          IN_wrValid,
    input  logic [NUM_WRITE*TAG_W-1:0]    IN_wrTag,
    input  logic [NUM_WRITE*DATA_W-1:0]   IN_wrData,
    output logic                          OUT_ready
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_REGS - 1);

    state_t                                state_q, state_d;
    logic [TAG_W-1:0]                      cnt_q, cnt_d;
    logic                                  ready_q, ready_d;
    logic [NUM_READ-1:0][DATA_W-1:0]       rd_data_q, rd_data_d;
    logic [DATA_W-1:0]                     mem_q [NUM_REGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_TAG) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Later write ports override earlier ones on a tag collision, for storage and bypass alike.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (IN_wrValid[w]) begin
                    mem_q[IN_wrTag[w*TAG_W +: TAG_W]] <= IN_wrData[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        for (int p = 0; p < NUM_READ; p++) begin
            if (IN_rdValid[p]) begin
                if (state_q == ST_INIT) begin
                    rd_data_d[p] = '0;
                end else begin
                    rd_data_d[p] = mem_q[IN_rdTag[p*TAG_W +: TAG_W]];
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (IN_wrValid[w] &&
                            (IN_wrTag[w*TAG_W +: TAG_W] == IN_rdTag[p*TAG_W +: TAG_W])) begin
                            rd_data_d[p] = IN_wrData[w*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign OUT_rdData = rd_data_q;
    assign OUT_ready  = ready_q;

endmodule

// File: tb/tb_int_reg_file.sv
// Randomized and directed bench for int_reg_file against an array-based model
// of the register file semantics (writes land first, reads see the result).
module tb_int_reg_file;

    localparam int NR = 6;
    localparam int NW = 4;
    localparam int NREGS = 64;
    localparam int DW = 32;
    localparam int TW = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NR-1:0]       rd_valid = '0;
    logic [NR*TW-1:0]    rd_tag = '0;
    logic [NR*DW-1:0]    rd_data;
    logic [NW-1:0]       wr_valid = '0;
    logic [NW*TW-1:0]    wr_tag = '0;
    logic [NW*DW-1:0]    wr_data = '0;
    logic                ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [NREGS];
    logic [DW-1:0] m_rd  [NR];
    bit            m_run;
    int            m_cnt;

    int_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .IN_rdValid (rd_valid),
        .IN_rdTag   (rd_tag),
        .OUT_rdData (rd_data),
        .IN_wrValid (wr_valid),
        .IN_wrTag   (wr_tag),
        .IN_wrData  (wr_data),
        .OUT_ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_valid = '0;
        wr_valid = '0;
    endtask

    task automatic set_rd(input int p, input int tag);
        rd_valid[p] = 1'b1;
        rd_tag[p*TW +: TW] = TW'(tag);
    endtask

    task automatic set_wr(input int w, input int tag, input logic [DW-1:0] d);
        wr_valid[w] = 1'b1;
        wr_tag[w*TW +: TW] = TW'(tag);
        wr_data[w*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] port_out(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        for (int p = 0; p < NR; p++) m_rd[p] = '0;
    endtask

    // Advance one clock: update the model, then compare every output.
    task automatic step();
        if (m_run) begin
            for (int w = 0; w < NW; w++)
                if (wr_valid[w]) m_mem[wr_tag[w*TW +: TW]] = wr_data[w*DW +: DW];
            for (int p = 0; p < NR; p++)
                if (rd_valid[p]) m_rd[p] = m_mem[rd_tag[p*TW +: TW]];
        end else begin
            m_mem[m_cnt] = '0;
            for (int p = 0; p < NR; p++)
                if (rd_valid[p]) m_rd[p] = '0;
            m_cnt++;
            if (m_cnt == NREGS) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ready", {31'b0, ready}, {31'b0, m_run});
        for (int p = 0; p < NR; p++) chk($sformatf("rd%0d", p), port_out(p), m_rd[p]);
    endtask

    // Async reset, then run the sweep; optionally spray writes at tag 2 during INIT.
    task automatic reset_and_init(input bit spray);
        int n;
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        for (int p = 0; p < NR; p++) chk($sformatf("rst_rd%0d", p), port_out(p), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            idle();
            if (spray) begin
                set_wr(0, 2, $urandom);
                set_wr(3, $urandom_range(0, 63), $urandom);
                if ($urandom_range(0, 1) == 1) set_rd(1, 2);
            end
            step();
            n++;
        end
        idle();
        chk("ready_lat", n, 64);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m_mem[i] = $urandom;
        model_reset();
        #2;
        reset_and_init(1'b0);

        // Read tag 17 in first RUN cycle.
        set_rd(0, 17);
        step();
        chk("first_run_rd17", port_out(0), 32'h0);

        // Write then read next cycle.
        idle(); set_wr(0, 5, 32'hDEADBEEF); step();
        idle(); set_rd(3, 5); step();
        chk("wr_then_rd", port_out(3), 32'hDEADBEEF);

        // Same-cycle bypass on two ports.
        idle(); set_wr(2, 9, 32'h12345678); set_rd(0, 9); set_rd(5, 9); step();
        chk("bypass_p0", port_out(0), 32'h12345678);
        chk("bypass_p5", port_out(5), 32'h12345678);

        // Hold while valid is low, even as the entry changes.
        idle();
        for (int i = 0; i < 4; i++) begin
            idle(); set_wr(1, 5, 32'h1); step();
            chk("hold_p3", port_out(3), 32'hDEADBEEF);
        end
        idle(); set_rd(3, 5); step();
        chk("rearm_p3", port_out(3), 32'h1);

        // Write collision: highest write port wins.
        idle(); set_wr(1, 40, 32'hA); set_wr(3, 40, 32'hB); set_rd(2, 40); step();
        chk("collide_bypass", port_out(2), 32'hB);
        idle(); set_rd(4, 40); step();
        chk("collide_store", port_out(4), 32'hB);

        // Randomized traffic, narrow tag range to provoke collisions and bypasses.
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 2) != 0)
                    set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7), $urandom);
            step();
        end

        // Reset mid-run: tag 2 must come back as 0 despite writes during INIT.
        idle(); set_wr(0, 2, 32'h55); step();
        idle(); set_rd(0, 2); step();
        chk("pre_rst_tag2", port_out(0), 32'h55);
        reset_and_init(1'b1);
        idle(); set_rd(0, 2); set_rd(5, 63); step();
        chk("post_rst_tag2", port_out(0), 32'h0);
        chk("post_rst_tag63", port_out(5), 32'h0);

        for (int c = 0; c < 100; c++) begin
            idle();
            for (int p = 0; p < NR; p++)
                if ($urandom_range(0, 1) == 1) set_rd(p, $urandom_range(0, 63));
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 1) == 1) set_wr(w, $urandom_range(0, 63), $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_reg_file.md
Name: int_reg_file

Overview:
- Integer physical register file: the responder side of the operand-load RF read interface.
- The load stage presents per-port read requests (valid + RFTag) in cycle N and consumes the data combinationally in cycle N+1.
- Writeback ports write results into the file.
- After reset, a sweep FSM clears the storage before the file reports ready. Storage is non-reset RAM-style.

Parameters:
- NUM_READ, 6, read ports (NUM_ALUS*2+NUM_AGUS ordering, owned by the requester).
- NUM_WRITE, 4, writeback ports.
- NUM_REGS, 64, physical registers; must be a power of 2.
- DATA_W, 32, register width.
- TAG_W, $clog2(NUM_REGS), RFTag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- IN_rdValid  in  NUM_READ  per-port read request valid.
- IN_rdTag  in  NUM_READ*TAG_W  per-port physical register tag.
- OUT_rdData  out  NUM_READ*DATA_W  per-port read data, registered, valid in the cycle after the request.
- IN_wrValid  in  NUM_WRITE  write enable. The writer already filters out constant/immediate tags.
- IN_wrTag  in  NUM_WRITE*TAG_W  write tag.
- IN_wrData  in  NUM_WRITE*DATA_W  write data.
- OUT_ready  out  1  high once the init sweep is done.

Behaviour:
- Reset (rst=0, asynchronous):
  - OUT_rdData all 0; OUT_ready=0; FSM=INIT; sweep counter=0.
  - Storage contents are don't-care.
  - Reset mid-sweep or mid-run restarts INIT from entry 0.
- FSM states:
  - INIT: each cycle, write 0 to entry[cnt], then cnt++.
    - When cnt==NUM_REGS-1 is written, go to RUN next cycle. The counter is TAG_W bits and is not allowed to wrap.
    - INIT lasts exactly NUM_REGS cycles after reset release.
    - In INIT, IN_wr* is ignored, OUT_ready=0, and any valid read returns 0 next cycle.
  - RUN: OUT_ready=1. There is no exit except reset.
- Read, 1-cycle latency:
  - If IN_rdValid[p] is high in cycle N, OUT_rdData[p] in cycle N+1 = the value of entry IN_rdTag[p] after all cycle-N writes are applied.
  - This is write-through bypass: a same-cycle write to the same tag is returned, not the stale value.
  - If IN_rdValid[p] is low, OUT_rdData[p] holds its previous value unchanged. The stalled requester relies on this to re-capture data while stalled.
  - All ports are independent; any number of ports may read the same tag in the same cycle.
- Write:
  - Entry is updated at the clock edge; visible to a read issued in the same cycle (via bypass) and in all later cycles.
  - Multiple valid writes to the same tag in one cycle are a protocol violation. Defined result: the highest write index wins, for both storage and bypass.
- No tag range checking: all TAG_W-bit values are legal.

Test Plan:
- Reset release, no traffic -> OUT_ready rises exactly 64 cycles after rst goes 1. A read of tag 17 in the first RUN cycle returns 0x00000000 next cycle.
- In RUN, write port 0 tag 5 = 0xDEADBEEF in cycle N; read port 3 tag 5 in cycle N+1 -> OUT_rdData[3]=0xDEADBEEF in cycle N+2.
- Same-cycle bypass: write port 2 tag 9 = 0x12345678 while read ports 0 and 5 request tag 9 in the same cycle -> both return 0x12345678 next cycle.
- Hold: read tag 5 (=0xDEADBEEF), then drop IN_rdValid[3] for 4 cycles while tag 5 is rewritten to 0x1 -> OUT_rdData[3] stays 0xDEADBEEF. Re-asserting valid returns 0x1 next cycle.
- Write collision: ports 1 and 3 both write tag 40 with 0xA and 0xB -> later read of tag 40 returns 0xB; a same-cycle bypass read also returns 0xB.
- Reset mid-run: set tag 2 = 0x55, assert rst for 1 cycle -> outputs 0 immediately and OUT_ready=0 asynchronously. After 64 init cycles, tag 2 reads 0, and writes issued during INIT are not retained.
